ecc_command_sequencer: RTL



---
 rtl/ecc_command_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ecc_command_sequencer.sv
// Command sequencer feeding the field-operation ROM: walks a window of command
// addresses a programmable number of times, then drains the pipeline with NOPs.
module ecc_command_sequencer #(
  parameter int Command_len = 6,
  parameter int Iter_len    = 8,
  parameter int Pipe_Depth  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [Command_len-1:0] prog_start,
  input  logic [Command_len-1:0] prog_end,
  input  logic [Iter_len-1:0]    iterations,
  input  logic                   stall,
  output logic [Command_len-1:0] Command,
  output logic                   cmd_valid,
  output logic                   busy,
  output logic                   done,
  output logic [Iter_len-1:0]    iter_cnt
);

  localparam int DW = (Pipe_Depth > 1) ? $clog2(Pipe_Depth) : 1;
  localparam logic [DW-1:0]          DRAIN_LAST = DW'(Pipe_Depth - 1);
  localparam logic [Command_len-1:0] CMD_NOP    = {Command_len{1'b0}};
  localparam logic [Command_len-1:0] PC_ONE     = {{(Command_len-1){1'b0}}, 1'b1};
  localparam logic [Iter_len-1:0]    ITER_ZERO  = {Iter_len{1'b0}};
  localparam logic [Iter_len-1:0]    ITER_ONE   = {{(Iter_len-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [Command_len-1:0] pc_q, pc_d;
  logic [Command_len-1:0] start_q, start_d;
  logic [Command_len-1:0] end_q, end_d;
  logic [Iter_len-1:0]    iters_q, iters_d;
  logic [Iter_len-1:0]    iter_q, iter_d;
  logic [DW-1:0]          cnt_q, cnt_d;
  logic [Command_len-1:0] cmd_q, cmd_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   run_invalid_s;

  assign run_invalid_s = (prog_start == CMD_NOP) || (prog_end < prog_start) ||
                         (iterations == ITER_ZERO);

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= CMD_NOP;
      start_q <= CMD_NOP;
      end_q   <= CMD_NOP;
      iters_q <= ITER_ZERO;
      iter_q  <= ITER_ZERO;
      cnt_q   <= {DW{1'b0}};
      cmd_q   <= CMD_NOP;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      start_q <= start_d;
      end_q   <= end_d;
      iters_q <= iters_d;
      iter_q  <= iter_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    start_d = start_q;
    end_d   = end_q;
    iters_d = iters_q;
    iter_d  = iter_q;
    cnt_d   = cnt_q;
    cmd_d   = CMD_NOP;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (run_invalid_s) begin
            state_d = DONE;
          end else begin
            start_d = prog_start;
            end_d   = prog_end;
            iters_d = iterations;
            pc_d    = prog_start;
            iter_d  = ITER_ZERO;
            busy_d  = 1'b1;
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (stall) begin
          cmd_d = CMD_NOP;
        end else begin
          cmd_d   = pc_q;
          valid_d = 1'b1;
          // Equality-only end test keeps a window ending at the top address from wrapping
          if (pc_q != end_q) begin
            pc_d = pc_q + PC_ONE;
          end else if ((iter_q + ITER_ONE) == iters_q) begin
            iter_d  = iter_q + ITER_ONE;
            cnt_d   = {DW{1'b0}};
            state_d = DRAIN;
          end else begin
            iter_d = iter_q + ITER_ONE;
            pc_d   = start_q;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = {DW{1'b0}};
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + {{(DW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign Command   = cmd_q;
  assign cmd_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign iter_cnt  = iter_q;

endmodule
